alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage directly downstream of the ALU control decoder. Consumes its 4-bit ctrlSignal,
//  both operands and the destination tag, performs the ALU operation, and registers result and flags
//  into the EX/MEM pipeline register. Uses a valid/ready handshake so MEM can stall. Flush squashes.
// PARAMETERS
//  XLEN      32   operand/result width
//  REGADDR_W 5    destination register index width
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous reset, active-high
//  flush        in   1          squash held and incoming ops (branch mispredict/trap)
//  inValid      in   1          ID/EX presents an op this cycle
//  inReady      out  1          stage accepts op this cycle
//  ctrlSignal   in   4          ALU op code from the ALU control decoder
//  srcA         in   XLEN       operand A
//  srcB         in   XLEN       operand B
//  rdIn         in   REGADDR_W  destination register index
//  regWriteIn   in   1          op writes rdIn
//  outValid     out  1          EX/MEM register holds a valid op
//  outReady     in   1          MEM consumes the held op this cycle
//  result       out  XLEN       registered ALU result
//  zero         out  1          registered (result == 0)
//  overflow     out  1          registered signed overflow (ADD/SUB only, else 0)
//  rdOut        out  REGADDR_W  registered destination index
//  regWriteOut  out  1          registered write enable (0 for illegal op)
//  illegalOp    out  1          registered: ctrlSignal was not a legal code
// BEHAVIOUR
//  - Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR. Others illegal.
//  - Reset (async, rst=1): outValid=0, result=0, zero=0, overflow=0, rdOut=0, regWriteOut=0,
//    illegalOp=0. inReady=0 while rst is high; after deassertion it is 1 (register empty).
//  - inReady = !flush && (!outValid || outReady) — combinational, no dependence on inValid.
//  - Accept: inValid && inReady at edge -> all outputs load next edge; latency exactly 1 cycle.
//  - Hold: outValid && !outReady -> every output register is stable; inputs are ignored.
//  - Drain without refill: outValid && outReady && !inValid -> outValid=0 next cycle. The data regs
//    may keep their old values.
//  - Back-to-back: an accept in every cycle with outReady=1 gives full throughput (one op/cycle).
//  - flush=1: outValid=0 next cycle, regardless of outReady or inValid. No op is accepted in the flush
//    cycle. A flush has priority over any simultaneous accept or hold.
//  - Arithmetic: all ops are XLEN-bit modulo. The SUB/SLT path is A + ~B + 1.
//    SLT result = {XLEN-1 zeros, (A<B signed)}, computed as sign ^ overflow of the subtraction.
//  - overflow: ADD gives (A[msb]==B[msb]) && (R[msb]!=A[msb]). SUB gives (A[msb]!=B[msb]) &&
//    (R[msb]!=A[msb]). It is 0 for all other ops.
//  - zero is computed from the final result for every op, including SLT.
//  - Illegal code: result=0, zero=1, overflow=0, regWriteOut=0, illegalOp=1. The op still flows
//    (outValid=1) so that the trap logic downstream sees it.
//  - Mid-operation reset: the held op is discarded immediately, no partial state survives.
// STRUCTURE
//  - alu_pkg: XLEN default, typedef enum logic[3:0] alu_op_e {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
//    ALU_SLT, ALU_NOR}, and an exec_result_t struct {result, zero, overflow, illegal}.
//  - Sub-module alu_core: purely combinational (ctrl, a, b) -> exec_result_t.
//    alu_exec_stage = alu_core + handshake control + EX/MEM register.
//  - One always_ff for valid/data with async reset; one always_comb for inReady.
// TESTING
//  1. Reset with rst=1 mid-hold (outValid=1, outReady=0) -> outValid=0 and all outputs 0 at once.
//     inReady=1 one cycle after release.
//  2. ADD A=32'h7FFF_FFFF B=1 -> result=32'h8000_0000, overflow=1, zero=0.
//     SUB A=5 B=5 -> result=0, zero=1, overflow=0.
//  3. SLT A=32'hFFFF_FFFF(-1) B=1 -> result=1. SLT A=1 B=-1 -> result=0, zero=1.
//     AND/OR/NOR of 32'hF0F0_F0F0 and 32'h0FF0_0FF0 -> 32'h00F0_00F0, 32'hFFF0_FFF0, 32'h000F_000F.
//  4. Stall: accept an op, hold outReady=0 for 3 cycles with new inValid=1 -> inReady=0 and outputs
//     unchanged. Then outReady=1 -> the new op is loaded the next cycle with no gap and no loss.
//  5. Flush while outValid=1 and inValid=1 -> inReady=0 that cycle and outValid=0 next cycle; the
//     incoming op never appears at the output.
//  6. ctrlSignal=4'b1111, rdIn=7, regWriteIn=1 -> outValid=1, illegalOp=1, regWriteOut=0, result=0.
//     A 10-op random stream with outReady toggling must match the reference model in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU op encodings and the ALU result bundle.
package alu_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REGADDR_W_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  // Result width follows XLEN_DEF; the stage is built at that width.
  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic                zero;
    logic                overflow;
    logic                illegal;
  } exec_result_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: decodes the 4-bit control code and produces result and flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]          i_ctrl,
  input  logic [XLEN_DEF-1:0] i_a,
  input  logic [XLEN_DEF-1:0] i_b,
  output exec_result_t        o_res
);

  localparam int MSB = XLEN_DEF - 1;

  logic [XLEN_DEF-1:0] w_sum;
  logic [XLEN_DEF-1:0] w_diff;
  logic                w_add_ovf;
  logic                w_sub_ovf;
  logic                w_lt;
  logic [XLEN_DEF-1:0] w_result;
  logic                w_ovf;
  logic                w_illegal;

  assign w_sum  = i_a + i_b;
  // SUB and SLT share a single subtractor: A + ~B + 1.
  assign w_diff = i_a + ~i_b + XLEN_DEF'(1);

  assign w_add_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
  assign w_sub_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
  // Signed less-than survives overflow by correcting the sign with the overflow bit.
  assign w_lt      = w_diff[MSB] ^ w_sub_ovf;

  // Op select; illegal codes force a zero result and raise the illegal flag.
  always_comb begin
    w_result  = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (i_ctrl)
      ALU_AND: w_result = i_a & i_b;
      ALU_OR:  w_result = i_a | i_b;
      ALU_ADD: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      ALU_SUB: begin
        w_result = w_diff;
        w_ovf    = w_sub_ovf;
      end
      ALU_SLT: w_result = {{(XLEN_DEF-1){1'b0}}, w_lt};
      ALU_NOR: w_result = ~(i_a | i_b);
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_res.result   = w_result;
  assign o_res.zero     = (w_result == '0);
  assign o_res.overflow = w_ovf;
  assign o_res.illegal  = w_illegal;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU core plus valid/ready handshake into the EX/MEM register, with flush.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [3:0]           ctrlSignal,
  input  logic [XLEN-1:0]      srcA,
  input  logic [XLEN-1:0]      srcB,
  input  logic [REGADDR_W-1:0] rdIn,
  input  logic                 regWriteIn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [XLEN-1:0]      result,
  output logic                 zero,
  output logic                 overflow,
  output logic [REGADDR_W-1:0] rdOut,
  output logic                 regWriteOut,
  output logic                 illegalOp
);

  exec_result_t         w_exec;
  logic                 w_accept;

  logic                 r_valid;
  logic [XLEN-1:0]      r_result;
  logic                 r_zero;
  logic                 r_overflow;
  logic [REGADDR_W-1:0] r_rd;
  logic                 r_reg_write;
  logic                 r_illegal;

  alu_core u_core (
    .i_ctrl (ctrlSignal),
    .i_a    (srcA),
    .i_b    (srcB),
    .o_res  (w_exec)
  );

  // Ready when not flushing and the register is empty or being drained this cycle.
  always_comb begin
    inReady = !rst && !flush && (!r_valid || outReady);
  end

  assign w_accept = inValid && inReady;

  // EX/MEM register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_result    <= w_exec.result;
      r_zero      <= w_exec.zero;
      r_overflow  <= w_exec.overflow;
      r_rd        <= rdIn;
      r_reg_write <= regWriteIn && !w_exec.illegal;
      r_illegal   <= w_exec.illegal;
    end else if (outReady) begin
      r_valid     <= 1'b0;
    end
  end

  assign outValid    = r_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_overflow;
  assign rdOut       = r_rd;
  assign regWriteOut = r_reg_write;
  assign illegalOp   = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and short random-stream bench for alu_exec_stage.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [3:0]  ctrlSignal;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  rdIn;
  logic        regWriteIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [4:0]  rdOut;
  logic        regWriteOut;
  logic        illegalOp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];

  alu_exec_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .inValid     (inValid),
    .inReady     (inReady),
    .ctrlSignal  (ctrlSignal),
    .srcA        (srcA),
    .srcB        (srcB),
    .rdIn        (rdIn),
    .regWriteIn  (regWriteIn),
    .outValid    (outValid),
    .outReady    (outReady),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .rdOut       (rdOut),
    .regWriteOut (regWriteOut),
    .illegalOp   (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    inValid    = 1'b1;
    ctrlSignal = c;
    srcA       = a;
    srcB       = b;
    rdIn       = rd;
    regWriteIn = rw;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] r, input logic z,
                           input logic o, input logic [4:0] rd, input logic rw, input logic il);
    chk({tag, "_valid"}, 32'(outValid),    32'(v));
    chk({tag, "_result"}, result,          r);
    chk({tag, "_zero"},  32'(zero),        32'(z));
    chk({tag, "_ovf"},   32'(overflow),    32'(o));
    chk({tag, "_rd"},    32'(rdOut),       32'(rd));
    chk({tag, "_rw"},    32'(regWriteOut), 32'(rw));
    chk({tag, "_ill"},   32'(illegalOp),   32'(il));
  endtask

  // Accept one op with outReady=1 and check what lands in the register.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic rw,
                        input logic [31:0] er, input logic ez, input logic eo,
                        input logic erw, input logic eil);
    outReady = 1'b1;
    drive(c, a, b, rd, rw);
    tick();
    inValid = 1'b0;
    check_out(tag, 1'b1, er, ez, eo, rd, erw, eil);
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic rw);
    exp_t e;
    e.res = 32'h0;
    e.o   = 1'b0;
    e.il  = 1'b0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        e.res = a + b;
        e.o   = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      4'b0110: begin
        e.res = a - b;
        e.o   = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
      default: e.il = 1'b1;
    endcase
    e.z  = (e.res == 32'h0);
    e.rd = rd;
    e.rw = rw && !e.il;
    return e;
  endfunction

  initial begin
    logic [3:0] ctrl_tab [8];
    int   cyc;
    int   consumed;
    int   issued;
    exp_t e;

    ctrl_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    ctrlSignal = 4'h0; srcA = 32'h0; srcB = 32'h0; rdIn = 5'd0; regWriteIn = 1'b0;

    // Reset values
    #1;
    check_out("rst", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("rst_inready", 32'(inReady), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_inready", 32'(inReady), 32'd1);

    // Arithmetic and logic directed vectors
    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd2, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 5'd3, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("slt_lt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("slt_ge", 4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("slt_ovfcase", 4'b0111, 32'h8000_0000, 32'h1, 5'd6, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8, 1'b1, 32'h00F0_00F0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9, 1'b1, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("nor", 4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd10, 1'b1, 32'h000F_000F, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("illegal", 4'b1111, 32'd5, 32'd6, 5'd7, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Stall: hold for 3 cycles with a pending op, then release with no gap
    run_op("stall_a", 4'b0010, 32'd10, 32'd20, 5'd3, 1'b1, 32'd30, 1'b0, 1'b0, 1'b1, 1'b0);
    outReady = 1'b0;
    drive(4'b0001, 32'd1, 32'd2, 5'd4, 1'b1);
    #1;
    chk("stall_inready", 32'(inReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall_hold", 1'b1, 32'd30, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      chk("stall_hold_inready", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    #1;
    chk("release_inready", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    check_out("stall_b", 1'b1, 32'd3, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    chk("drain_valid", 32'(outValid), 32'd0);

    // Flush with a held op and an incoming op
    run_op("flush_pre", 4'b0000, 32'hFF, 32'h0F, 5'd11, 1'b1, 32'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    outReady = 1'b0;
    drive(4'b0010, 32'd100, 32'd1, 5'd12, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_inready", 32'(inReady), 32'd0);
    tick();
    chk("flush_valid", 32'(outValid), 32'd0);
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    tick();
    chk("flush_noleak_valid", 32'(outValid), 32'd0);
    chk("flush_noleak_result", result, 32'h0F);

    // Asynchronous reset while holding
    run_op("hold_pre", 4'b0010, 32'd10, 32'd20, 5'd3, 1'b1, 32'd30, 1'b0, 1'b0, 1'b1, 1'b0);
    outReady = 1'b0;
    tick();
    chk("hold_valid", 32'(outValid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_out("midrst", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("midrst_inready", 32'(inReady), 32'd0);
    tick();
    rst = 1'b0;
    outReady = 1'b1;
    tick();
    chk("midrst_release_inready", 32'(inReady), 32'd1);
    chk("midrst_release_valid", 32'(outValid), 32'd0);

    // Random 10-op stream against the reference model with outReady toggling
    cyc = 0; consumed = 0; issued = 0;
    while (consumed < 10 && cyc < 400) begin
      outReady = ($urandom_range(0, 1) == 1);
      if (issued < 10 && $urandom_range(0, 3) != 0) begin
        drive(ctrl_tab[$urandom_range(0, 7)],
              ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
              ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (outValid && outReady) begin
        chk("rand_q_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rand_result", result, e.res);
          chk("rand_zero", 32'(zero), 32'(e.z));
          chk("rand_ovf", 32'(overflow), 32'(e.o));
          chk("rand_ill", 32'(illegalOp), 32'(e.il));
          chk("rand_rd", 32'(rdOut), 32'(e.rd));
          chk("rand_rw", 32'(regWriteOut), 32'(e.rw));
        end
        consumed++;
      end
      if (inValid && inReady) begin
        q.push_back(model(ctrlSignal, srcA, srcB, rdIn, regWriteIn));
        issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    inValid = 1'b0;
    chk("rand_consumed", 32'(consumed), 32'd10);
    chk("rand_q_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
